// File: rtl/noc_collect_pkg.sv
// Shared types and field offsets for the tree-NoC result collector.
// The packet layout is {payload, source address, destination}, with the destination in the LSBs.
package noc_collect_pkg;

  localparam int DEF_WIDTH_PACKET = 28;
  localparam int DEF_WIDTH_ADDR   = 3;
  localparam int DEF_WIDTH_DEST   = 3;

  localparam int DEST_LSB = 0;
  localparam int ADDR_LSB = DEF_WIDTH_DEST;
  localparam int DATA_LSB = DEF_WIDTH_ADDR + DEF_WIDTH_DEST;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    DONE
  } collect_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_collect_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins.
// The caller owns the priority pointer and decides when it advances.
module rr_arbiter
  import noc_collect_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_collect_arbiter.sv
// Merges leaf-port packets into the single result sink. Each accepted word is tagged with its source
// and a sequence index, misrouted packets are dropped and counted, and done is raised after NUM_PACKETS.
module output_collect_arbiter
  import noc_collect_pkg::*;
#(
  parameter int WIDTH_packet = DEF_WIDTH_PACKET,
  parameter int WIDTH_addr   = DEF_WIDTH_ADDR,
  parameter int WIDTH_dest   = DEF_WIDTH_DEST,
  parameter int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
  parameter int NUM_REQ      = 4,
  parameter int NUM_PACKETS  = 20,
  parameter logic [WIDTH_dest-1:0] SINK_DEST = '0,
  parameter int CNT_W        = $clog2(NUM_PACKETS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_packet,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH_packet-1:0]  out_data,
  output logic [WIDTH_addr-1:0]    out_src,
  output logic [CNT_W-1:0]         out_index,
  output logic                     done,
  output logic [7:0]               err_count
);

  localparam int IDX_W    = idx_width(NUM_REQ);
  localparam int ADDR_OFF = DEST_LSB + WIDTH_dest;
  localparam int DATA_OFF = ADDR_OFF + WIDTH_addr;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PACKETS);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  collect_state_t state, state_next;

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [CNT_W-1:0]   acc_cnt;
  logic [CNT_W-1:0]   del_cnt;
  logic [WIDTH-1:0]   sel_packet;
  logic               can_load;
  logic               accept;
  logic               good;
  logic               out_hs;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // Packet select is driven by the one-hot grant so req_ready never depends on packet contents.
  always_comb begin
    sel_packet = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_packet = req_packet[i*WIDTH +: WIDTH];
    end
  end

  assign can_load  = (state == COLLECT) && (!out_valid || out_ready);
  assign req_ready = can_load ? grant : '0;
  assign accept    = can_load && grant_valid;
  assign good      = accept && (sel_packet[DEST_LSB +: WIDTH_dest] == SINK_DEST);
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (good && (acc_cnt + ONE == LAST_CNT)) state_next = DRAIN;
      DRAIN:   if (out_hs && (del_cnt + ONE == LAST_CNT)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
  end

  // A good load takes priority over clearing out_valid, giving back-to-back words on drain+load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_index  <= '0;
      acc_cnt    <= '0;
      del_cnt    <= '0;
      err_count  <= '0;
      done       <= 1'b0;
    end else begin
      if (accept) last_grant <= grant_idx;
      if (good) begin
        out_data  <= sel_packet[DATA_OFF +: WIDTH_packet];
        out_src   <= sel_packet[ADDR_OFF +: WIDTH_addr];
        out_index <= acc_cnt;
        acc_cnt   <= acc_cnt + ONE;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (accept && !good && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (out_hs) del_cnt <= del_cnt + ONE;
      if (state_next == DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_collect_arbiter.sv
// Self-checking bench for output_collect_arbiter: directed vector table, hand sequences for
// completion and reset-in-drain, then randomized traffic against a transaction-level model.
module tb_output_collect_arbiter;
  import noc_collect_pkg::*;

  localparam int NREQ = 4;
  localparam int NPKT = 20;
  localparam int W    = 34;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [4*W-1:0]  req_packet;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [27:0]     out_data;
  logic [2:0]      out_src;
  logic [4:0]      out_index;
  logic            done;
  logic [7:0]      err_count;

  int checks = 0;
  int errors = 0;

  output_collect_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_packet(req_packet),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_index (out_index),
    .done      (done),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] bad;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    int         exp_row;
    int         exp_leaf;
    int         exp_idx;
    int         exp_err;
  } vec_t;

  vec_t tbl[22];

  // Transaction-level reference: held word, counters, priority pointer.
  int          m_ptr, m_acc, m_del, m_err, m_src, m_idx;
  bit          m_ov, m_done;
  logic [27:0] m_data;
  logic [W-1:0] m_pkt;

  function automatic logic [W-1:0] mk_pkt(input logic [27:0] d, input logic [2:0] a, input logic [2:0] dst);
    logic [W-1:0] p;
    p = '0;
    p[DATA_LSB +: 28] = d;
    p[ADDR_LSB +: 3]  = a;
    p[DEST_LSB +: 3]  = dst;
    return p;
  endfunction

  function automatic logic [27:0] row_data(input int r, input int i);
    return 28'h0A00000 | 28'(r << 4) | 28'(i);
  endfunction

  function automatic logic [4*W-1:0] row_packets(input int r, input logic [3:0] bad);
    logic [4*W-1:0] p;
    p = '0;
    for (int i = 0; i < NREQ; i++)
      p[i*W +: W] = mk_pkt(row_data(r, i), 3'(i + 3), bad[i] ? 3'd3 : 3'd0);
    return p;
  endfunction

  function automatic vec_t mkv(input logic [3:0] rv, input logic [3:0] bad, input logic ordy,
                               input logic [3:0] rdy, input logic ov, input int row, input int leaf,
                               input int idx, input int err);
    vec_t v;
    v.rv = rv; v.bad = bad; v.ordy = ordy; v.exp_rdy = rdy; v.exp_ov = ov;
    v.exp_row = row; v.exp_leaf = leaf; v.exp_idx = idx; v.exp_err = err;
    return v;
  endfunction

  function automatic int model_grant(input logic [3:0] rv);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (rv[c]) return c;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic [4*W-1:0] pk, input logic ordy);
    req_valid  = rv;
    req_packet = pk;
    out_ready  = ordy;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0, '0, 1'b0);
    m_ptr = NREQ - 1; m_acc = 0; m_del = 0; m_err = 0; m_ov = 0; m_done = 0;
    m_data = '0; m_src = 0; m_idx = 0;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_out_index", out_index, 0);
    checkOutput("reset_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Leaf 0 streams n good packets at full rate; the index must track the accept count.
  task automatic runGood(input int n);
    logic [4*W-1:0] pk;
    for (int k = 0; k < n; k++) begin
      pk = '0;
      pk[W-1:0] = mk_pkt(28'h0100 + 28'(k), 3'd2, 3'd0);
      applyStimulus(4'b0001, pk, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("run%0d_req_ready", k), req_ready, 4'b0001);
      @(posedge clk);
      #1;
      checkOutput($sformatf("run%0d_out_index", k), out_index, k);
      checkOutput($sformatf("run%0d_out_valid", k), out_valid, 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]     rv;
    logic [4*W-1:0] pk;
    logic           ordy;
    logic [3:0]     erdy;
    logic [2:0]     dst;
    int             g;
    bit             can, hs;

    for (int r = 0; r < 8; r++) tbl[r] = mkv(4'hF, 4'h0, 1, 4'(1 << (r % 4)), 1, r, r % 4, r, 0);
    tbl[8] = mkv(4'h3, 4'h0, 1, 4'h1, 1, 8, 0, 8, 0);
    for (int r = 9; r < 14; r++) tbl[r] = mkv(4'h3, 4'h0, 0, 4'h0, 1, 8, 0, 8, 0);
    tbl[14] = mkv(4'h3, 4'h0, 1, 4'h2, 1, 14, 1, 9, 0);
    tbl[15] = mkv(4'h2, 4'h2, 1, 4'h2, 0, 0, 0, 0, 1);
    tbl[16] = mkv(4'h4, 4'h0, 1, 4'h4, 1, 16, 2, 10, 1);
    tbl[17] = mkv(4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 1);
    tbl[18] = mkv(4'h2, 4'h2, 0, 4'h2, 0, 0, 0, 0, 2);
    tbl[19] = mkv(4'h8, 4'h0, 0, 4'h8, 1, 19, 3, 11, 2);
    tbl[20] = mkv(4'h8, 4'h8, 0, 4'h0, 1, 19, 3, 11, 2);
    tbl[21] = mkv(4'h8, 4'h8, 1, 4'h8, 0, 0, 0, 0, 3);

    doReset();

    // Single word from leaf 2: ready in the same cycle, output one cycle later.
    pk = '0;
    pk[2*W +: W] = mk_pkt(28'h0ABCDEF, 3'd5, 3'd0);
    applyStimulus(4'b0100, pk, 1'b1);
    @(negedge clk);
    checkOutput("single_req_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    checkOutput("single_out_valid", out_valid, 1);
    checkOutput("single_out_data", out_data, 28'h0ABCDEF);
    checkOutput("single_out_src", out_src, 5);
    checkOutput("single_out_index", out_index, 0);

    doReset();
    for (int r = 0; r < 22; r++) begin
      applyStimulus(tbl[r].rv, row_packets(r, tbl[r].bad), tbl[r].ordy);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].exp_rdy);
      @(posedge clk);
      #1;
      checkOutput($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].exp_ov);
      checkOutput($sformatf("tbl%0d_err_count", r), err_count, tbl[r].exp_err);
      checkOutput($sformatf("tbl%0d_done", r), done, 0);
      if (tbl[r].exp_ov) begin
        checkOutput($sformatf("tbl%0d_out_data", r), out_data, row_data(tbl[r].exp_row, tbl[r].exp_leaf));
        checkOutput($sformatf("tbl%0d_out_src", r), out_src, tbl[r].exp_leaf + 3);
        checkOutput($sformatf("tbl%0d_out_index", r), out_index, tbl[r].exp_idx);
      end
    end

    // Completion: done rises on the handshake of the last word; later requests are never acked.
    doReset();
    runGood(NPKT);
    applyStimulus(4'b0001, '0, 1'b1);
    @(negedge clk);
    checkOutput("drain_req_ready", req_ready, 4'b0000);
    checkOutput("drain_done_before", done, 0);
    @(posedge clk);
    #1;
    checkOutput("done_rise", done, 1);
    checkOutput("done_out_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, '0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("done%0d_req_ready", k), req_ready, 4'b0000);
      checkOutput($sformatf("done%0d_sticky", k), done, 1);
      checkOutput($sformatf("done%0d_out_valid", k), out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Reset between edges while the last word is held in DRAIN.
    doReset();
    runGood(NPKT);
    applyStimulus(4'b0001, '0, 1'b0);
    @(negedge clk);
    checkOutput("hold_req_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("hold_out_valid", out_valid, 1);
    checkOutput("hold_out_index", out_index, NPKT - 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_out_index", out_index, 0);
    checkOutput("async_done", done, 0);
    applyStimulus(4'b0000, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(4'b1111, row_packets(1, 4'h0), 1'b1);
    @(negedge clk);
    checkOutput("post_reset_req_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    checkOutput("post_reset_out_index", out_index, 0);
    checkOutput("post_reset_out_src", out_src, 3);

    // Randomized traffic against the reference model.
    for (int ep = 0; ep < 3; ep++) begin
      doReset();
      for (int cyc = 0; cyc < 150; cyc++) begin
        rv = 4'($urandom);
        for (int i = 0; i < NREQ; i++) begin
          dst = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
          pk[i*W +: W] = mk_pkt(28'($urandom), 3'($urandom), dst);
        end
        ordy = ($urandom_range(0, 9) < 7);
        can  = !m_done && (m_acc < NPKT) && (!m_ov || ordy);
        g    = model_grant(rv);
        erdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
        applyStimulus(rv, pk, ordy);
        @(negedge clk);
        checkOutput("rnd_req_ready", req_ready, erdy);
        @(posedge clk);
        #1;
        hs = m_ov && ordy;
        if (hs) m_del++;
        if (can && g >= 0) begin
          m_pkt = pk[g*W +: W];
          m_ptr = g;
          if (m_pkt[DEST_LSB +: 3] == 3'd0) begin
            m_data = m_pkt[DATA_LSB +: 28];
            m_src  = int'(m_pkt[ADDR_LSB +: 3]);
            m_idx  = m_acc;
            m_acc++;
            m_ov   = 1;
          end else begin
            if (m_err < 255) m_err++;
            if (hs) m_ov = 0;
          end
        end else if (hs) begin
          m_ov = 0;
        end
        if (m_del == NPKT) m_done = 1;
        checkOutput("rnd_out_valid", out_valid, m_ov);
        checkOutput("rnd_done", done, m_done);
        checkOutput("rnd_err_count", err_count, m_err);
        if (m_ov) begin
          checkOutput("rnd_out_data", out_data, m_data);
          checkOutput("rnd_out_src", out_src, m_src);
          checkOutput("rnd_out_index", out_index, m_idx);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
